piezo_burst_scheduler: RTL and testbench

- Sequences the shared piezo transducer between two requesters: the PTP piezo interface (requester 0) and the RTC event logic (requester 1).
- For each granted request it runs driver-enable settle, a square-wave burst on the piezo output, a guard interval, and a receive window.
- During the receive window it timestamps the first rising echo edge against the system time bus.
- Sits between the Avalon-side timing IPs and the piezo pins (driver enable, drive, receiver enable, echo input).

---
 rtl/piezo_burst_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_piezo_burst_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_burst_scheduler.sv
// piezo_burst_scheduler
// Arbitrates the shared piezo transducer between the PTP piezo interface
// (requester 0) and the RTC event logic (requester 1). Each granted request
// runs: driver-enable settle, square-wave burst, guard interval, and a
// receive window that timestamps the first rising echo edge.
//
// Ports:
//   iCLK, iRESET          clock, asynchronous active-high reset
//   iREQ[1:0]             request levels (bit0 PTP, bit1 RTC)
//   oGNT[1:0]             one-hot grant, held for the whole sequence
//   oDONE[1:0]            one-cycle completion pulse to the granted requester
//   oBUSY                 high whenever the sequencer is not idle
//   iHALF_PERIOD[15:0]    drive half-period in cycles (0 treated as 1)
//   iPULSE_COUNT[7:0]     number of drive periods (0 skips the burst)
//   iLISTEN_CYC[23:0]     receive window length (0 skips listening)
//   iTIME[TW-1:0]         free-running system time
//   iECHO                 asynchronous receive comparator
//   oENABLE_OUT, oPIEZO   driver enable and drive signal
//   oENABLE_IN            receiver enable
//   oHIT, oTS[TW-1:0]     echo result of the last sequence
module piezo_burst_scheduler #(
    parameter int SETTLE_CYC  = 8,
    parameter int GUARD_CYC   = 4,
    parameter int TW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          iCLK,
    input  logic          iRESET,
    input  logic [1:0]    iREQ,
    output logic [1:0]    oGNT,
    output logic [1:0]    oDONE,
    output logic          oBUSY,
    input  logic [15:0]   iHALF_PERIOD,
    input  logic [7:0]    iPULSE_COUNT,
    input  logic [23:0]   iLISTEN_CYC,
    input  logic [TW-1:0] iTIME,
    input  logic          iECHO,
    output logic          oENABLE_OUT,
    output logic          oPIEZO,
    output logic          oENABLE_IN,
    output logic          oHIT,
    output logic [TW-1:0] oTS
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_DRIVE  = 3'd2,
        S_GUARD  = 3'd3,
        S_LISTEN = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      gnt_reg, gnt_next;
    logic [1:0]      done_reg, done_next;
    logic            busy_reg, busy_next;
    logic            en_out_reg, en_out_next;
    logic            piezo_reg, piezo_next;
    logic            en_in_reg, en_in_next;
    logic            hit_reg, hit_next;
    logic [TW-1:0]   ts_reg, ts_next;
    logic            last_reg, last_next;      // requester served most recently
    logic [15:0]     half_reg, half_next;      // latched half-period, already forced >= 1
    logic [7:0]      pulses_reg, pulses_next;  // latched period count
    logic [23:0]     listen_reg, listen_next;  // latched receive window length
    logic [15:0]     hp_cnt_reg, hp_cnt_next;  // cycles left in current half-period
    logic [8:0]      pulse_cnt_reg, pulse_cnt_next; // half-periods left after the current one
    logic [23:0]     tmr_reg, tmr_next;        // settle / guard / listen down-counter

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   echo_prev_reg;
    logic                   echo_s;
    logic                   echo_edge;
    logic                   pick;

    assign echo_s    = sync_reg[SYNC_STAGES-1];
    assign echo_edge = echo_s & ~echo_prev_reg;

    // Echo synchronizer and edge history
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            sync_reg      <= '0;
            echo_prev_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], iECHO};
            echo_prev_reg <= echo_s;
        end
    end

    // State and registered outputs
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_reg     <= S_IDLE;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            busy_reg      <= 1'b0;
            en_out_reg    <= 1'b0;
            piezo_reg     <= 1'b0;
            en_in_reg     <= 1'b0;
            hit_reg       <= 1'b0;
            ts_reg        <= '0;
            last_reg      <= 1'b1;  // requester 0 wins the first tie
            half_reg      <= 16'd1;
            pulses_reg    <= 8'd0;
            listen_reg    <= 24'd0;
            hp_cnt_reg    <= 16'd0;
            pulse_cnt_reg <= 9'd0;
            tmr_reg       <= 24'd0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
            en_out_reg    <= en_out_next;
            piezo_reg     <= piezo_next;
            en_in_reg     <= en_in_next;
            hit_reg       <= hit_next;
            ts_reg        <= ts_next;
            last_reg      <= last_next;
            half_reg      <= half_next;
            pulses_reg    <= pulses_next;
            listen_reg    <= listen_next;
            hp_cnt_reg    <= hp_cnt_next;
            pulse_cnt_reg <= pulse_cnt_next;
            tmr_reg       <= tmr_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        done_next      = 2'b00;
        piezo_next     = piezo_reg;
        hit_next       = hit_reg;
        ts_next        = ts_reg;
        last_next      = last_reg;
        half_next      = half_reg;
        pulses_next    = pulses_reg;
        listen_next    = listen_reg;
        hp_cnt_next    = hp_cnt_reg;
        pulse_cnt_next = pulse_cnt_reg;
        tmr_next       = tmr_reg;
        pick           = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (|iREQ) begin
                    // On a tie serve the requester that was not served last
                    pick        = (iREQ == 2'b11) ? ~last_reg : iREQ[1];
                    gnt_next    = pick ? 2'b10 : 2'b01;
                    last_next   = pick;
                    half_next   = (iHALF_PERIOD == 16'd0) ? 16'd1 : iHALF_PERIOD;
                    pulses_next = iPULSE_COUNT;
                    listen_next = iLISTEN_CYC;
                    tmr_next    = 24'(SETTLE_CYC - 1);
                    state_next  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_reg == 24'd0) begin
                    if (pulses_reg == 8'd0) begin
                        tmr_next   = 24'(GUARD_CYC - 1);
                        state_next = S_GUARD;
                    end else begin
                        piezo_next     = 1'b1;
                        hp_cnt_next    = half_reg - 16'd1;
                        pulse_cnt_next = {pulses_reg, 1'b0} - 9'd1;
                        state_next     = S_DRIVE;
                    end
                end else begin
                    tmr_next = tmr_reg - 24'd1;
                end
            end
            S_DRIVE: begin
                if (hp_cnt_reg == 16'd0) begin
                    if (pulse_cnt_reg == 9'd0) begin
                        tmr_next   = 24'(GUARD_CYC - 1);
                        state_next = S_GUARD;
                    end else begin
                        piezo_next     = ~piezo_reg;
                        pulse_cnt_next = pulse_cnt_reg - 9'd1;
                        hp_cnt_next    = half_reg - 16'd1;
                    end
                end else begin
                    hp_cnt_next = hp_cnt_reg - 16'd1;
                end
            end
            S_GUARD: begin
                if (tmr_reg == 24'd0) begin
                    if (listen_reg == 24'd0) begin
                        hit_next   = 1'b0;
                        ts_next    = '0;
                        done_next  = gnt_reg;
                        state_next = S_DONE;
                    end else begin
                        tmr_next   = listen_reg - 24'd1;
                        state_next = S_LISTEN;
                    end
                end else begin
                    tmr_next = tmr_reg - 24'd1;
                end
            end
            S_LISTEN: begin
                if (echo_edge) begin
                    hit_next   = 1'b1;
                    ts_next    = iTIME;
                    done_next  = gnt_reg;
                    state_next = S_DONE;
                end else if (tmr_reg == 24'd0) begin
                    hit_next   = 1'b0;
                    ts_next    = '0;
                    done_next  = gnt_reg;
                    state_next = S_DONE;
                end else begin
                    tmr_next = tmr_reg - 24'd1;
                end
            end
            S_DONE: begin
                gnt_next   = 2'b00;
                state_next = S_IDLE;
            end
            default: begin
                gnt_next   = 2'b00;
                state_next = S_IDLE;
            end
        endcase

        // Enables follow the upcoming state; drive is only allowed in DRIVE
        busy_next   = (state_next != S_IDLE);
        en_out_next = (state_next == S_SETTLE) || (state_next == S_DRIVE) ||
                      (state_next == S_GUARD);
        en_in_next  = (state_next == S_LISTEN);
        piezo_next  = piezo_next & (state_next == S_DRIVE);
    end

    assign oGNT        = gnt_reg;
    assign oDONE       = done_reg;
    assign oBUSY       = busy_reg;
    assign oENABLE_OUT = en_out_reg;
    assign oPIEZO      = piezo_reg;
    assign oENABLE_IN  = en_in_reg;
    assign oHIT        = hit_reg;
    assign oTS         = ts_reg;

endmodule

// File: tb/tb_piezo_burst_scheduler.sv
// tb_piezo_burst_scheduler
// Directed bench for piezo_burst_scheduler: drives request/config vectors,
// traces each sequence cycle by cycle and compares against hand-computed
// timing, burst pattern, arbitration order and echo timestamp.
module tb_piezo_burst_scheduler;

    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          busy;
    logic [15:0]   half_period;
    logic [7:0]    pulse_count;
    logic [23:0]   listen_cyc;
    logic [TW-1:0] time_bus;
    logic          echo;
    logic          enable_out;
    logic          piezo;
    logic          enable_in;
    logic          hit;
    logic [TW-1:0] ts;

    piezo_burst_scheduler #(
        .SETTLE_CYC (8),
        .GUARD_CYC  (4),
        .TW         (TW),
        .SYNC_STAGES(2)
    ) dut (
        .iCLK        (clk),
        .iRESET      (rst),
        .iREQ        (req),
        .oGNT        (gnt),
        .oDONE       (done),
        .oBUSY       (busy),
        .iHALF_PERIOD(half_period),
        .iPULSE_COUNT(pulse_count),
        .iLISTEN_CYC (listen_cyc),
        .iTIME       (time_bus),
        .iECHO       (echo),
        .oENABLE_OUT (enable_out),
        .oPIEZO      (piezo),
        .oENABLE_IN  (enable_in),
        .oHIT        (hit),
        .oTS         (ts)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Per-sequence trace results
    int          r_busy, r_en_out, r_en_in, r_viol, r_idle;
    logic [31:0] r_pat;
    logic [1:0]  r_done, r_gnt;
    logic        r_hit;
    logic [TW-1:0] r_ts;
    logic [TW-1:0] exp_ts;
    int          rst_done;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge; iTIME for the cycle ending at the
    // following rising edge is the running cycle number.
    task automatic tick();
        @(negedge clk);
        cyc++;
        time_bus = cyc;
    endtask

    task automatic set_cfg(input logic [15:0] h, input logic [7:0] n, input logic [23:0] l);
        half_period = h;
        pulse_count = n;
        listen_cyc  = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Trace one sequence from the current point up to and including oDONE.
    task automatic run_seq(input bit drop_req, input int echo_at,
                           input int chg_at, input logic [15:0] chg_val);
        int  n;
        bit  fin;
        r_busy = 0; r_en_out = 0; r_en_in = 0; r_viol = 0; r_idle = 0;
        r_pat = '0; r_done = '0; r_gnt = '0; r_hit = 1'b0; r_ts = '0;
        exp_ts = '0;
        fin = 1'b0;
        n = 0;
        while (!fin && n < 2000) begin
            tick();
            n++;
            if ((enable_in && enable_out) || (piezo && !enable_out)) r_viol++;
            if (busy) r_busy++; else r_idle++;
            if (enable_out) begin
                r_en_out++;
                r_pat = {r_pat[30:0], piezo};
                if (chg_at > 0 && r_en_out == chg_at) half_period = chg_val;
            end
            if (enable_in) begin
                r_en_in++;
                if (echo_at > 0 && r_en_in == echo_at) echo = 1'b1;
                if (echo_at > 0 && r_en_in == echo_at + 2) exp_ts = cyc;
            end
            if (drop_req && busy && r_busy == 1) req = 2'b00;
            if (done != 2'b00) begin
                fin    = 1'b1;
                r_done = done;
                r_gnt  = gnt;
                r_hit  = hit;
                r_ts   = ts;
            end
        end
        if (!fin) check_eq("seq_timeout", 64'd0, 64'd1);
        $display("[TB] seq gnt=%b done=%b busy=%0d en_out=%0d en_in=%0d pat=%h hit=%b ts=%0d idle=%0d",
                 r_gnt, r_done, r_busy, r_en_out, r_en_in, r_pat, r_hit, r_ts, r_idle);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; echo = 1'b0; time_bus = '0;
        set_cfg(16'd0, 8'd0, 24'd0);
        repeat (3) tick();
        check_eq("rst_outs", {gnt, done, busy, enable_out, piezo, enable_in, hit}, 9'd0);
        check_eq("rst_ts", ts, 0);
        rst = 1'b0;
        tick();
        check_eq("idle_outs", {gnt, done, busy, enable_out, piezo, enable_in, hit}, 9'd0);

        // 1: basic burst, no echo
        set_cfg(16'd2, 8'd3, 24'd100);
        req = 2'b01;
        run_seq(1'b1, 0, 0, 16'd0);
        check_eq("t1_idle", r_idle, 0);
        check_eq("t1_gnt", r_gnt, 2'b01);
        check_eq("t1_done", r_done, 2'b01);
        check_eq("t1_en_out", r_en_out, 24);
        check_eq("t1_pat", r_pat, 32'h0000_CCC0);
        check_eq("t1_en_in", r_en_in, 100);
        check_eq("t1_busy", r_busy, 125);
        check_eq("t1_hit", r_hit, 1'b0);
        check_eq("t1_ts", r_ts, 0);
        check_eq("t1_viol", r_viol, 0);

        // 2: echo 40 cycles into the window
        req = 2'b01;
        run_seq(1'b1, 40, 0, 16'd0);
        echo = 1'b0;
        check_eq("t2_en_in", r_en_in, 42);
        check_eq("t2_busy", r_busy, 67);
        check_eq("t2_hit", r_hit, 1'b1);
        check_eq("t2_ts", r_ts, exp_ts);
        check_eq("t2_done", r_done, 2'b01);
        tick(); tick();
        check_eq("t2_hold_hit", hit, 1'b1);
        check_eq("t2_hold_ts", ts, exp_ts);
        check_eq("t2_idle_outs", {gnt, done, busy}, 5'd0);

        // 3: both requesting, round robin from a fresh reset
        do_reset();
        set_cfg(16'd1, 8'd1, 24'd2);
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            run_seq(1'b0, 0, 0, 16'd0);
            check_eq("t3_gnt", r_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            check_eq("t3_done", r_done, (i % 2 == 0) ? 2'b01 : 2'b10);
            check_eq("t3_idle", r_idle, (i == 0) ? 0 : 1);
            check_eq("t3_busy", r_busy, 17);
        end
        req = 2'b00;

        // 4: no burst, no listen
        set_cfg(16'd5, 8'd0, 24'd0);
        req = 2'b01;
        run_seq(1'b1, 0, 0, 16'd0);
        check_eq("t4_busy", r_busy, 13);
        check_eq("t4_en_out", r_en_out, 12);
        check_eq("t4_pat", r_pat, 32'd0);
        check_eq("t4_en_in", r_en_in, 0);
        check_eq("t4_done", r_done, 2'b01);

        // 5: reset mid-burst, then serve requester 1
        set_cfg(16'd3, 8'd4, 24'd50);
        req = 2'b01;
        repeat (11) tick();
        check_eq("t5_pre_drive", {enable_out, piezo}, 2'b11);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_async_outs", {gnt, done, busy, enable_out, piezo, enable_in, hit}, 9'd0);
        rst_done = 0;
        repeat (3) begin
            tick();
            if (done != 2'b00) rst_done++;
        end
        check_eq("t5_no_done", rst_done, 0);
        rst = 1'b0;
        set_cfg(16'd1, 8'd2, 24'd5);
        req = 2'b10;
        run_seq(1'b1, 0, 0, 16'd0);
        check_eq("t5_gnt", r_gnt, 2'b10);
        check_eq("t5_done", r_done, 2'b10);
        check_eq("t5_pat", r_pat, 32'h0000_00A0);
        check_eq("t5_en_in", r_en_in, 5);
        check_eq("t5_busy", r_busy, 22);

        // 6a: echo already high, half-period changed mid-burst
        echo = 1'b1;
        set_cfg(16'd2, 8'd2, 24'd10);
        req = 2'b01;
        run_seq(1'b1, 0, 10, 16'd7);
        echo = 1'b0;
        check_eq("t6_pat", r_pat, 32'h0000_0CC0);
        check_eq("t6_en_in", r_en_in, 10);
        check_eq("t6_hit", r_hit, 1'b0);
        check_eq("t6_ts", r_ts, 0);

        // 6b: H=0 behaves as H=1
        set_cfg(16'd0, 8'd3, 24'd0);
        req = 2'b01;
        run_seq(1'b1, 0, 0, 16'd0);
        check_eq("t6_h0_pat", r_pat, 32'h0000_02A0);
        check_eq("t6_h0_busy", r_busy, 19);
        check_eq("t6_h0_viol", r_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
